// File: rtl/route_compute_unit_pkg.sv
// ----------------------------------------------------------------------------
// route_compute_unit_pkg
// Shared constants for the mesh NoC route computation unit and its route
// function: output port codes, routing mode selectors and FSM state codes.
// Also holds a small helper that maps an output port code to the matching
// congestion flag.
// ----------------------------------------------------------------------------
package route_compute_unit_pkg;

  // Output port codes seen by the switch allocator.
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
  localparam logic [2:0] OUT_X1_PORT    = 3'd1;  // towards smaller x (west)
  localparam logic [2:0] OUT_X2_PORT    = 3'd2;  // towards larger x (east)
  localparam logic [2:0] OUT_Y1_PORT    = 3'd3;  // towards smaller y
  localparam logic [2:0] OUT_Y2_PORT    = 3'd4;  // towards larger y

  // Routing algorithm selectors.
  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;
  localparam int ROUTE_WF = 2;

  // Wormhole state machine encodings.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Registered output descriptor.
  typedef struct packed {
    logic [2:0] port;
    logic       tail;
  } out_desc_t;

  // Congestion flags are packed {Y2, Y1, X2, X1}; returns the busy flag of
  // the given output direction (LOCAL is never congested).
  function automatic logic port_busy(input logic [2:0] port,
                                     input logic [3:0] cong);
    logic busy;
    case (port)
      OUT_X1_PORT: busy = cong[0];
      OUT_X2_PORT: busy = cong[1];
      OUT_Y1_PORT: busy = cong[2];
      OUT_Y2_PORT: busy = cong[3];
      default:     busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/route_compute_unit_route_fn.sv
// ----------------------------------------------------------------------------
// route_fn
// Purely combinational route function. Given this router's address, the
// destination address and the congestion flags, returns the output port for
// a head flit under the selected routing mode (XY, YX or west-first minimal
// adaptive). Kept separate so lookahead routing can reuse it.
//
// Ports:
//   router_add  in  X_W+Y_W  this router's address {y, x}
//   in_dst      in  X_W+Y_W  destination address {y, x}
//   cong        in  4        congestion flags {Y2, Y1, X2, X1}, 1 = busy
//   port        out 3        selected output port code
// ----------------------------------------------------------------------------
module route_fn
  import route_compute_unit_pkg::*;
#(
  parameter int X_W  = 2,
  parameter int Y_W  = 1,
  parameter int MODE = 0
) (
  input  logic [X_W+Y_W-1:0] router_add,
  input  logic [X_W+Y_W-1:0] in_dst,
  input  logic [3:0]         cong,
  output logic [2:0]         port
);

  logic [X_W-1:0] cx;
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] cy;
  logic [Y_W-1:0] dy;

  assign cx = router_add[X_W-1:0];
  assign cy = router_add[X_W+Y_W-1:X_W];
  assign dx = in_dst[X_W-1:0];
  assign dy = in_dst[X_W+Y_W-1:X_W];

  logic [2:0] x_dir;
  logic [2:0] y_dir;
  logic [2:0] xy_port;
  logic [2:0] yx_port;
  logic [2:0] wf_port;
  logic       x2_busy;
  logic       y_busy;

  // Minimal direction along each axis (only meaningful when that axis differs).
  always_comb begin
    x_dir = (cx < dx) ? OUT_X2_PORT : OUT_X1_PORT;
    y_dir = (cy < dy) ? OUT_Y2_PORT : OUT_Y1_PORT;
  end

  always_comb begin
    if (cx != dx)      xy_port = x_dir;
    else if (cy == dy) xy_port = OUT_LOCAL_PORT;
    else               xy_port = y_dir;
  end

  always_comb begin
    if (cy != dy)      yx_port = y_dir;
    else if (cx == dx) yx_port = OUT_LOCAL_PORT;
    else               yx_port = x_dir;
  end

  // West-first: any westward hop must be taken first, so X1 is never a choice
  // alongside other directions. Otherwise pick among the remaining productive
  // directions, preferring X2 unless it alone is congested.
  always_comb begin
    x2_busy = port_busy(OUT_X2_PORT, cong);
    y_busy  = port_busy(y_dir, cong);
    if (dx < cx)                     wf_port = OUT_X1_PORT;
    else if (dx == cx && dy == cy)   wf_port = OUT_LOCAL_PORT;
    else if (dx == cx)               wf_port = y_dir;
    else if (dy == cy)               wf_port = OUT_X2_PORT;
    else if (x2_busy && !y_busy)     wf_port = y_dir;
    else                             wf_port = OUT_X2_PORT;
  end

  // Unknown mode values fall back to XY.
  always_comb begin
    case (MODE)
      ROUTE_YX: port = yx_port;
      ROUTE_WF: port = wf_port;
      default:  port = xy_port;
    endcase
  end

endmodule

// File: rtl/route_compute_unit.sv
// ----------------------------------------------------------------------------
// route_compute_unit
// Per-input-port route computation for the mesh NoC router. Head flits get an
// output port from route_fn; the port is locked for the remaining flits of
// the packet (wormhole). One registered pipeline stage with valid/ready sits
// between the input buffer and the switch allocator.
//
// Ports:
//   clk         in   1        clock
//   rst         in   1        asynchronous active-high reset
//   router_add  in   X_W+Y_W  this router's address, static after reset
//   in_valid    in   1        flit descriptor valid
//   in_ready    out  1        descriptor accepted this cycle when valid
//   in_head     in   1        head flit
//   in_tail     in   1        tail flit (head+tail = single-flit packet)
//   in_dst      in   X_W+Y_W  destination, used on head flits only
//   cong        in   4        congestion flags {Y2, Y1, X2, X1}
//   out_valid   out  1        routed descriptor valid
//   out_ready   in   1        downstream accepts
//   out_port    out  3        output port code
//   out_tail    out  1        registered in_tail
//   err         out  1        sticky protocol-error flag
// ----------------------------------------------------------------------------
module route_compute_unit
  import route_compute_unit_pkg::*;
#(
  parameter int X_W  = 2,
  parameter int Y_W  = 1,
  parameter int MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_W+Y_W-1:0] router_add,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_head,
  input  logic               in_tail,
  input  logic [X_W+Y_W-1:0] in_dst,
  input  logic [3:0]         cong,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_port,
  output logic               out_tail,
  output logic               err
);

  logic [0:0] state_q,     state_d;
  logic [2:0] lock_q,      lock_d;
  logic       err_q,       err_d;
  logic       out_valid_q, out_valid_d;
  out_desc_t  desc_q,      desc_d;

  logic [2:0] route_port;
  logic       xfer;

  route_fn #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .MODE (MODE)
  ) u_route_fn (
    .router_add (router_add),
    .in_dst     (in_dst),
    .cong       (cong),
    .port       (route_port)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // State, lock and output stage only move on an accepted descriptor; a held
  // output simply drains when downstream takes it with nothing new behind.
  // The lock register follows every head flit, so a stray body flit in IDLE
  // reuses the route of the most recent head.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    desc_d      = desc_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      desc_d.tail = in_tail;
      if (in_head) begin
        // A head while locked aborts the old packet and starts a new one.
        if (state_q == ST_LOCKED) err_d = 1'b1;
        desc_d.port = route_port;
        lock_d      = route_port;
        state_d     = in_tail ? ST_IDLE : ST_LOCKED;
      end else begin
        desc_d.port = lock_q;
        if (state_q == ST_IDLE) begin
          err_d = 1'b1;
        end else if (in_tail) begin
          state_d = ST_IDLE;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_q      <= OUT_LOCAL_PORT;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      desc_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      desc_q      <= desc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_port  = desc_q.port;
  assign out_tail  = desc_q.tail;
  assign err       = err_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// ----------------------------------------------------------------------------
// tb_route_compute_unit
// Drives three instances (XY, YX, west-first) with shared stimulus. Accepted
// descriptors are turned into expected outputs by a reference model and
// queued per instance; a monitor pops and compares whenever an instance
// hands an output downstream.
// ----------------------------------------------------------------------------
module tb_route_compute_unit;
  import route_compute_unit_pkg::*;

  localparam int X_W = 2;
  localparam int Y_W = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] router_add;
  logic       in_valid;
  logic       in_head;
  logic       in_tail;
  logic [2:0] in_dst;
  logic [3:0] cong;
  logic       out_ready;

  logic       in_ready_w  [3];
  logic       out_valid_w [3];
  logic [2:0] out_port_w  [3];
  logic       out_tail_w  [3];
  logic       err_w       [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      route_compute_unit #(
        .X_W  (X_W),
        .Y_W  (Y_W),
        .MODE (gi)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .router_add (router_add),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w[gi]),
        .in_head    (in_head),
        .in_tail    (in_tail),
        .in_dst     (in_dst),
        .cong       (cong),
        .out_valid  (out_valid_w[gi]),
        .out_ready  (out_ready),
        .out_port   (out_port_w[gi]),
        .out_tail   (out_tail_w[gi]),
        .err        (err_w[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] port;
    logic       tail;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 toggle, 3 stalled

  // Reference model state: is a packet in progress, the last head's route,
  // and whether a protocol error has been seen.
  bit         m_in_pkt [3];
  logic [2:0] m_route  [3];
  bit         m_err    [3];

  // Route from the algorithm descriptions on plain integers.
  function automatic logic [2:0] model_route(input int mode, input logic [2:0] d,
                                             input logic [3:0] c);
    int cx, cy, dx, dy;
    logic [2:0] xd, yd;
    bit x_busy, y_busy;
    cx = int'(router_add[1:0]);
    cy = int'(router_add[2]);
    dx = int'(d[1:0]);
    dy = int'(d[2]);
    xd = (dx > cx) ? 3'd2 : 3'd1;
    yd = (dy > cy) ? 3'd4 : 3'd3;
    if (mode == 1) begin
      if (dy != cy) return yd;
      if (dx != cx) return xd;
      return 3'd0;
    end else if (mode == 2) begin
      if (dx < cx) return 3'd1;
      if (dx == cx && dy == cy) return 3'd0;
      if (dx == cx) return yd;
      if (dy == cy) return 3'd2;
      x_busy = c[1];
      y_busy = (yd == 3'd4) ? c[3] : c[2];
      if (x_busy && !y_busy) return yd;
      return 3'd2;
    end
    if (dx != cx) return xd;
    if (dy != cy) return yd;
    return 3'd0;
  endfunction

  task automatic model_accept(input bit h, input bit t, input logic [2:0] d,
                              input logic [3:0] c);
    exp_t e;
    for (int m = 0; m < 3; m++) begin
      if (h) begin
        if (m_in_pkt[m]) m_err[m] = 1'b1;
        m_route[m]  = model_route(m, d, c);
        m_in_pkt[m] = !t;
      end else begin
        if (!m_in_pkt[m]) m_err[m] = 1'b1;
        else if (t)       m_in_pkt[m] = 1'b0;
      end
      e.port = m_route[m];
      e.tail = t;
      e.err  = m_err[m];
      case (m)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_in_pkt[m] = 1'b0;
      m_route[m]  = 3'd0;
      m_err[m]    = 1'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, want);
    end
  endtask

  task automatic check_port(input string name, input logic [2:0] got,
                            input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_pop(input int m);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (m)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_out mode=%0d: got port=%0d with nothing expected",
               m, out_port_w[m]);
    end else if (out_port_w[m] !== e.port || out_tail_w[m] !== e.tail ||
                 err_w[m] !== e.err) begin
      errors++;
      $display("FAIL out mode=%0d: got port=%0d tail=%0b err=%0b expected port=%0d tail=%0b err=%0b",
               m, out_port_w[m], out_tail_w[m], err_w[m], e.port, e.tail, e.err);
    end else begin
      $display("txn mode=%0d port=%0d tail=%0b err=%0b", m, e.port, e.tail, e.err);
    end
  endtask

  // Monitor: outputs are checked mid-cycle, when a handoff will happen at the
  // coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (in_ready_w[1] !== in_ready_w[0] || in_ready_w[2] !== in_ready_w[0]) begin
          checks++;
          errors++;
          $display("FAIL in_ready_agree: got %0b/%0b/%0b", in_ready_w[0],
                   in_ready_w[1], in_ready_w[2]);
        end
        for (int m = 0; m < 3; m++) begin
          if (out_valid_w[m] && out_ready) check_pop(m);
        end
      end
    end
  end

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Present one descriptor and hold it until accepted; returns at posedge+1.
  task automatic send(input bit h, input bit t, input logic [2:0] d,
                      input logic [3:0] c);
    bit accepted;
    in_valid = 1'b1;
    in_head  = h;
    in_tail  = t;
    in_dst   = d;
    cong     = c;
    accepted = 1'b0;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        accepted = 1'b1;
        model_accept(h, t, d, c);
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready in 200 cycles, expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (q0.size() + q1.size() + q2.size()) > 0; k++)
      @(negedge clk);
    checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still pending, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0] dir_dst  [9];
  logic [3:0] dir_cong [9];

  initial begin
    router_add = 3'b001;
    in_valid   = 1'b0;
    in_head    = 1'b0;
    in_tail    = 1'b0;
    in_dst     = 3'b000;
    cong       = 4'b0000;
    rst        = 1'b1;
    model_reset();
    #12;
    for (int m = 0; m < 3; m++) begin
      check_bit("reset_out_valid", out_valid_w[m], 1'b0);
      check_port("reset_out_port", out_port_w[m], 3'd0);
      check_bit("reset_out_tail", out_tail_w[m], 1'b0);
      check_bit("reset_err", err_w[m], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-flit packets covering each routing rule, back to back.
    dir_dst  = '{3'b011, 3'b100, 3'b001, 3'b101, 3'b000, 3'b111, 3'b111, 3'b111, 3'b100};
    dir_cong = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b0001};
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) send(1'b1, 1'b1, dir_dst[i], dir_cong[i]);
    drain();

    // Multi-flit packet under a toggling downstream ready.
    rdy_mode = 2;
    send(1'b1, 1'b0, 3'b011, 4'b0000);
    send(1'b0, 1'b0, 3'b000, 4'b0000);
    send(1'b0, 1'b0, 3'b000, 4'b0000);
    send(1'b0, 1'b1, 3'b000, 4'b0000);
    rdy_mode = 0;
    drain();
    for (int m = 0; m < 3; m++) check_bit("no_err_after_packet", err_w[m], 1'b0);

    // Protocol errors: body in IDLE, then head while LOCKED.
    send(1'b0, 1'b0, 3'b000, 4'b0000);
    send(1'b1, 1'b0, 3'b011, 4'b0000);
    send(1'b1, 1'b1, 3'b101, 4'b0000);
    drain();
    for (int m = 0; m < 3; m++) check_bit("err_sticky", err_w[m], 1'b1);

    // Asynchronous reset while an output is held mid-packet.
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 3'b011, 4'b0000);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      check_bit("async_rst_out_valid", out_valid_w[m], 1'b0);
      check_port("async_rst_out_port", out_port_w[m], 3'd0);
      check_bit("async_rst_err", err_w[m], 1'b0);
    end
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(1'b0, 1'b1, 3'b000, 4'b0000);
    send(1'b1, 1'b1, 3'b110, 4'b0000);
    drain();

    // Randomised packets with occasional protocol violations.
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int f = 0; f < len; f++) begin
        bit h, t;
        h = (f == 0);
        t = (f == len - 1);
        if ($urandom_range(0, 29) == 0) h = !h;
        send(h, t, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
